// File: rtl/dmem_pkg.sv
// Shared constants, region enum and byte-merge helper for the data-memory responder.
// The timer window is enabled by DMEM_MMIO_EN; the package itself does not depend on it.
package dmem_pkg;

  localparam logic [3:0] OFF_COUNT  = 4'h0;
  localparam logic [3:0] OFF_CMP    = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  localparam int ST_MATCH = 0;
  localparam int ST_FAULT = 1;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

  // Lane n takes newWord when be[n] is set, otherwise keeps oldWord.
  function automatic logic [31:0] byteMerge(input logic [31:0] oldWord,
                                            input logic [31:0] newWord,
                                            input logic [3:0]  be);
    logic [31:0] merged;
    merged = oldWord;
    for (int n = 0; n < 4; n++) begin
      if (be[n]) merged[8*n +: 8] = newWord[8*n +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_responder_mmio_timer.sv
// Memory-mapped timer: free-running COUNT, CMP and the sticky MATCH flag driving irq.
// Instantiated by dmem_responder only when DMEM_MMIO_EN is defined.
module mmio_timer
  import dmem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wrCount_i,
  input  logic        wrCmp_i,
  input  logic        wrStatus_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  rdOffset_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        match_q, match_d;

  // A same-cycle match beats a W1C clear, so the set is applied last.
  always_comb begin
    count_d = count_q + 32'd1;
    if (wrCount_i) count_d = byteMerge(count_q, wdata_i, be_i);
    cmp_d = cmp_q;
    if (wrCmp_i) cmp_d = byteMerge(cmp_q, wdata_i, be_i);
    match_d = match_q;
    if (wrStatus_i && be_i[0] && wdata_i[ST_MATCH]) match_d = 1'b0;
    if (count_q == cmp_q) match_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 32'h0000_0000;
      cmp_q   <= 32'hFFFF_FFFF;
      match_q <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (rdOffset_i)
      OFF_COUNT:  rdata_o = count_q;
      OFF_CMP:    rdata_o = cmp_q;
      OFF_STATUS: rdata_o[ST_MATCH] = match_q;
      default:    rdata_o = '0;
    endcase
  end

  assign irq_o = match_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM, sticky access-fault flag and, with
// DMEM_MMIO_EN defined, a memory-mapped timer window at MMIO_BASE.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [3:0]  be,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        fault,
  output logic        irq
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]   mem [DEPTH_WORDS];
  region_e       region;
  logic [AW-1:0] wordIdx;
  logic          faultSet, faultClr;
  logic          fault_q, fault_d;
  logic          unusedBits;

  assign wordIdx = ALUResult[AW+1:2];

  always_comb begin
    region = REG_NONE;
    if (ALUResult < RAM_BYTES) region = REG_RAM;
`ifdef DMEM_MMIO_EN
    else if (ALUResult[31:4] == MMIO_BASE[31:4]) region = REG_MMIO;
`endif
  end

  // RAM is deliberately not reset; a store seen while reset is high is dropped.
  always_ff @(posedge clk) begin
    if (!reset && MemWrite && (region == REG_RAM)) begin
      for (int n = 0; n < 4; n++) begin
        if (be[n]) mem[wordIdx][8*n +: 8] <= WriteData[8*n +: 8];
      end
    end
  end

`ifdef DMEM_MMIO_EN
  logic [3:0]  mmioOff;
  logic        mmioWr;
  logic [31:0] timerRdata;
  logic        timerIrq;

  assign mmioOff    = {ALUResult[3:2], 2'b00};
  assign mmioWr     = MemWrite && (region == REG_MMIO);
  assign unusedBits = ^ALUResult[1:0];

  mmio_timer uTimer (
    .clk_i      (clk),
    .rst_i      (reset),
    .wrCount_i  (mmioWr && (mmioOff == OFF_COUNT)),
    .wrCmp_i    (mmioWr && (mmioOff == OFF_CMP)),
    .wrStatus_i (mmioWr && (mmioOff == OFF_STATUS)),
    .be_i       (be),
    .wdata_i    (WriteData),
    .rdOffset_i (mmioOff),
    .rdata_o    (timerRdata),
    .irq_o      (timerIrq)
  );

  assign irq = timerIrq;
  assign faultClr = mmioWr && (mmioOff == OFF_STATUS) && be[0] && WriteData[ST_FAULT];
`else
  assign unusedBits = ^{ALUResult[1:0], MMIO_BASE};
  assign irq        = 1'b0;
  assign faultClr   = 1'b0;
`endif

  // Idle cycles drive be=0 with no store, so they never raise the fault.
  always_comb begin
    faultSet = (region == REG_NONE) && (MemWrite || (be != 4'b0000));
    fault_d  = fault_q;
    if (faultClr) fault_d = 1'b0;
    if (faultSet) fault_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fault = fault_q;

  always_comb begin
    ReadData = '0;
    case (region)
      REG_RAM: ReadData = mem[wordIdx];
`ifdef DMEM_MMIO_EN
      REG_MMIO: begin
        ReadData = timerRdata;
        if (mmioOff == OFF_STATUS) ReadData[ST_FAULT] = fault_q;
      end
`endif
      default: ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; timer checks run when
// DMEM_MMIO_EN is defined, the compiled-out window is checked otherwise.
module tb_dmem_responder;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [3:0]  be;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        fault;
  logic        irq;

  int testsRun    = 0;
  int testsFailed = 0;

  dmem_responder #(.DEPTH_WORDS(64), .MMIO_BASE(MMIO_BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .be        (be),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .fault     (fault),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic we, input logic [3:0] b,
                               input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = we;
    be        = b;
    ALUResult = addr;
    WriteData = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    checkOutput("reset_fault", {31'h0, fault}, 32'h0);
    checkOutput("reset_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;

    applyStimulus(1'b1, 4'hF, 32'h10, 32'hAABB_CCDD);
    tick();
    applyStimulus(1'b1, 4'b0010, 32'h10, 32'h0000_EE00);
    tick();
    applyStimulus(1'b0, 4'hF, 32'h10, 32'h0);
    #1;
    checkOutput("lane_merge", ReadData, 32'hAABB_EEDD);
    checkOutput("ram_no_fault", {31'h0, fault}, 32'h0);

    applyStimulus(1'b1, 4'hF, 32'h20, 32'h1122_3344);
    tick();
    applyStimulus(1'b1, 4'hF, 32'h20, 32'h5566_7788);
    #1;
    checkOutput("same_cycle_old", ReadData, 32'h1122_3344);
    tick();
    applyStimulus(1'b0, 4'hF, 32'h20, 32'h0);
    #1;
    checkOutput("next_cycle_new", ReadData, 32'h5566_7788);

    applyStimulus(1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF);
    tick();
    applyStimulus(1'b0, 4'hF, 32'h20, 32'h0);
    #1;
    checkOutput("be0_noop", ReadData, 32'h5566_7788);

    applyStimulus(1'b1, 4'hF, 32'hFC, 32'hDEAD_BEEF);
    tick();
    applyStimulus(1'b0, 4'hF, 32'hFC, 32'h0);
    #1;
    checkOutput("last_word", ReadData, 32'hDEAD_BEEF);
    tick();
    checkOutput("last_word_no_fault", {31'h0, fault}, 32'h0);

    applyStimulus(1'b0, 4'h0, 32'h100, 32'h0);
    #1;
    checkOutput("idle_unmapped_data", ReadData, 32'h0);
    tick();
    checkOutput("idle_unmapped_no_fault", {31'h0, fault}, 32'h0);

    applyStimulus(1'b1, 4'hF, 32'h0, 32'hCAFE_F00D);
    tick();
    applyStimulus(1'b1, 4'hF, 32'h100, 32'h1234_5678);
    tick();
    checkOutput("unmapped_write_fault", {31'h0, fault}, 32'h1);
    applyStimulus(1'b0, 4'hF, 32'h0, 32'h0);
    #1;
    checkOutput("no_alias_word0", ReadData, 32'hCAFE_F00D);

    reset = 1'b1;
    #2;
    checkOutput("async_reset_fault", {31'h0, fault}, 32'h0);
    reset = 1'b0;
    tick();
    applyStimulus(1'b0, 4'hF, 32'h0000_1000, 32'h0);
    #1;
    checkOutput("unmapped_read_data", ReadData, 32'h0);
    tick();
    checkOutput("unmapped_read_fault", {31'h0, fault}, 32'h1);

`ifdef DMEM_MMIO_EN
    applyStimulus(1'b1, 4'h1, MMIO_BASE + 32'h8, 32'h2);
    tick();
    checkOutput("w1c_fault", {31'h0, fault}, 32'h0);

    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    applyStimulus(1'b1, 4'hF, MMIO_BASE + 32'h4, 32'h5);
    tick();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 4'hF, MMIO_BASE, 32'h0);
      #1;
      checkOutput($sformatf("count_%0d", i), ReadData, 32'(i));
      checkOutput($sformatf("irq_low_%0d", i), {31'h0, irq}, 32'h0);
      tick();
    end
    checkOutput("match_irq", {31'h0, irq}, 32'h1);
    applyStimulus(1'b0, 4'hF, MMIO_BASE + 32'h8, 32'h0);
    #1;
    checkOutput("status_match", ReadData, 32'h1);
    applyStimulus(1'b1, 4'h1, MMIO_BASE + 32'h8, 32'h1);
    tick();
    checkOutput("w1c_match", {31'h0, irq}, 32'h0);

    applyStimulus(1'b1, 4'hF, MMIO_BASE + 32'h4, 32'h9);
    tick();
    applyStimulus(1'b0, 4'hF, MMIO_BASE, 32'h0);
    #1;
    checkOutput("count_8", ReadData, 32'h8);
    tick();
    applyStimulus(1'b1, 4'h1, MMIO_BASE + 32'h8, 32'h1);
    tick();
    checkOutput("set_beats_w1c", {31'h0, irq}, 32'h1);

    applyStimulus(1'b1, 4'hF, MMIO_BASE, 32'hFFFF_FFFE);
    tick();
    applyStimulus(1'b0, 4'hF, MMIO_BASE, 32'h0);
    #1;
    checkOutput("wrap_0", ReadData, 32'hFFFF_FFFE);
    tick();
    checkOutput("wrap_1", ReadData, 32'hFFFF_FFFF);
    tick();
    checkOutput("wrap_2", ReadData, 32'h0000_0000);
    tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_count", ReadData, 32'h0);
    checkOutput("reset_irq_mid", {31'h0, irq}, 32'h0);
    reset = 1'b0;

    applyStimulus(1'b1, 4'b0001, MMIO_BASE + 32'h4, 32'h0000_00AB);
    tick();
    applyStimulus(1'b0, 4'hF, MMIO_BASE + 32'h4, 32'h0);
    #1;
    checkOutput("cmp_merge", ReadData, 32'hFFFF_FFAB);
    applyStimulus(1'b0, 4'hF, MMIO_BASE + 32'hC, 32'h0);
    #1;
    checkOutput("reserved_data", ReadData, 32'h0);
    tick();
    checkOutput("reserved_no_fault", {31'h0, fault}, 32'h0);
`else
    reset = 1'b1;
    #2;
    reset = 1'b0;
    applyStimulus(1'b0, 4'hF, MMIO_BASE, 32'h0);
    #1;
    checkOutput("off_mmio_data", ReadData, 32'h0);
    tick();
    checkOutput("off_mmio_fault", {31'h0, fault}, 32'h1);
    checkOutput("off_irq_a", {31'h0, irq}, 32'h0);
    applyStimulus(1'b1, 4'h1, MMIO_BASE + 32'h8, 32'h2);
    tick();
    checkOutput("off_fault_sticky", {31'h0, fault}, 32'h1);
    checkOutput("off_irq_b", {31'h0, irq}, 32'h0);
    applyStimulus(1'b0, 4'hF, MMIO_BASE + 32'h8, 32'h0);
    #1;
    checkOutput("off_status_data", ReadData, 32'h0);
`endif

    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle ARM core. It services the core's load/store interface: address on `ALUResult`, store data on `WriteData`, `MemWrite`, and byte enables `be`, and it returns `ReadData`. It holds a word-addressed RAM with byte-lane writes. A small memory-mapped timer block (free-running cycle counter, compare register, sticky status with interrupt) decodes at a fixed base. It also keeps a sticky access-fault flag for out-of-range accesses.

## Interface
Parameters:
- `DEPTH_WORDS`, 64: RAM size in 32-bit words; power of two, at least 4.
- `MMIO_BASE`, 32'hFFFF_0000: base byte address of the timer registers. The window is 16 bytes.

Ports:
- `clk`  input  1: sole clock, rising-edge.
- `reset`  input  1: asynchronous, active-high reset.
- `MemWrite`  input  1: store strobe for the current cycle.
- `be`  input  4: byte-lane enables. Bit n selects `WriteData[8n+7:8n]`.
- `ALUResult`  input  32: byte address. Bits [1:0] are ignored.
- `WriteData`  input  32: store data, already lane-aligned by the core.
- `ReadData`  output  32: load data, combinational.
- `fault`  output  1: sticky flag, set by an access outside both the RAM and the MMIO window.
- `irq`  output  1: equals the timer match flag. Tied 0 when MMIO is compiled out.

## Operation
- Address decode, with word index = `ALUResult[31:2]`:
  - RAM region: byte address below `DEPTH_WORDS*4`.
  - MMIO region: `MMIO_BASE` to `MMIO_BASE+15`.
  - Anything else is unmapped.
- Reads
  - Always a full word. `be` is ignored on reads; the core extracts bytes itself.
  - RAM reads return the stored word.
  - Unmapped reads return 32'h0.
  - Reads have no side effects.
- RAM writes
  - Happen when `MemWrite` is 1.
  - Only lanes with `be[n]=1` are updated. A write with `be`=0 is a no-op.
- Unmapped access
  - An unmapped read or write sets `fault` at the next edge.
  - Unmapped writes are dropped.
  - An unmapped read sets `fault` only when `MemWrite`=0 and `be`≠0. This filters idle cycles: the core drives `be`=0 on non-memory instructions.
- MMIO registers (offset from `MMIO_BASE`):
  - 0x0 COUNT: increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0. A write loads COUNT, byte-merged per `be`. The load has priority over the increment in that cycle.
  - 0x4 CMP: read/write with byte merge. Reset value 32'hFFFF_FFFF.
  - 0x8 STATUS: bit0 = MATCH, bit1 = FAULT; other bits read 0. Writing 1 to a bit clears it (W1C, lane 0 only); writing 0 has no effect.
  - 0xC: reserved. Reads return 0; writes are ignored; no fault.
- MATCH
  - Set at the edge after a cycle in which registered COUNT equals registered CMP.
  - If set and W1C clear happen in the same cycle, set wins.
- FAULT follows the same rule: set wins over a same-cycle W1C. `fault` is the FAULT bit.

## Timing
- Read latency is zero: `ReadData` is combinational from `ALUResult` and the current state.
- Writes commit on the rising `clk` edge. Write data is visible to a read in the following cycle, not in the same cycle.
- COUNT reads return the pre-increment registered value of that cycle.
- Reset values:
  - COUNT=0, CMP=32'hFFFF_FFFF, MATCH=0, FAULT=0, `fault`=0, `irq`=0.
  - `ReadData` follows decode combinationally.
  - RAM contents are not reset and are undefined until written.
- Reset asserted mid-operation clears all registers immediately (asynchronous). A store presented during reset is dropped.

## Configuration
- `DMEM_MMIO_EN` defined:
  - The timer block and MMIO window exist as described.
- `DMEM_MMIO_EN` undefined:
  - No counter, CMP, or STATUS registers.
  - The MMIO window decodes as unmapped: reads return 0 and set `fault`; writes are dropped and set `fault`.
  - `irq` is tied 0.
  - `fault` is cleared only by reset.

## Structure
- Package `dmem_pkg` holds:
  - MMIO offset constants: `OFF_COUNT`, `OFF_CMP`, `OFF_STATUS`.
  - Status bit indices `ST_MATCH`, `ST_FAULT`.
  - A region enum `{REG_RAM, REG_MMIO, REG_NONE}`.
  - A byte-merge function (old word, new word, `be`).
- One sub-module, `mmio_timer`, owns COUNT, CMP, and MATCH. It takes decoded write strobes, `be`, and data, and returns read data and `irq`. It is instantiated only under `DMEM_MMIO_EN`.
- FAULT stays in the top level, because it exists in both configurations.

## Test plan
- RAM byte-lane store:
  - Store 32'hAABBCCDD to 0x10 with `be`=4'b1111.
  - Then store 32'h0000_EE00 with `be`=4'b0010.
  - A read of 0x10 returns 32'hAABBEEDD.
- Same-cycle visibility: a store to 0x20 plus a read of 0x20 in the same cycle returns the old value; the next cycle returns the new value.
- Unmapped access:
  - Read 0x0000_1000 with `be`=4'hF (`DEPTH_WORDS`=64): returns 0, and `fault`=1 after the edge.
  - Then write 32'h2 to STATUS: `fault`=0 after the edge.
- Timer match:
  - After reset, write CMP=5.
  - MATCH/`irq` rise at the edge after COUNT reads 5.
  - W1C bit0 clears it.
  - A W1C issued in the cycle COUNT==CMP leaves MATCH=1.
- Counter load and wrap:
  - Write COUNT=32'hFFFF_FFFE, then read on consecutive cycles.
  - Expected sequence: FFFF_FFFE, FFFF_FFFF, 0000_0000.
  - Assert `reset` asynchronously mid-run: COUNT=0 immediately.
- `DMEM_MMIO_EN` undefined: a read of `MMIO_BASE` returns 0 and sets `fault`, and `irq` stays 0 throughout.
